// File: rtl/mem_loader.sv
// mem_loader: streams words into memory, optionally verifies by XOR checksum readback, then triggers execution
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 8
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 32
`endif

module mem_loader #(
  parameter int          ADDR_W     = `MEMORY_ADDR_WIDTH,
  parameter int          DATA_W     = `MEMORY_DATA_WIDTH,
  parameter logic [1:0]  FUNC_READ  = 2'b00,
  parameter logic [1:0]  FUNC_WRITE = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              verify_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data,
  output logic              mem_execute,
  output logic [1:0]        mem_func,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_count,
  output logic              exec_start
);
  typedef enum logic [2:0] {
    IDLE, ACCEPT, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, FINISH, FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] wsum_q, wsum_d;
  logic [DATA_W-1:0] rsum_q, rsum_d;
  logic [1:0]        func_q, func_d;
  logic              ver_q, ver_d;
  logic              last_q, last_d;
  logic              first_q, first_d;
  logic              err_q, err_d;

  assign mem_func   = func_q;
  assign address    = addr_q;
  assign write_data = wdata_q;
  assign word_count = cnt_q;
  assign error      = err_q;
  assign busy       = state_q != IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wsum_q  <= '0;
      rsum_q  <= '0;
      func_q  <= '0;
      ver_q   <= 1'b0;
      last_q  <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
      func_q  <= func_d;
      ver_q   <= ver_d;
      last_q  <= last_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wsum_d      = wsum_q;
    rsum_d      = rsum_q;
    func_d      = func_q;
    ver_d       = ver_q;
    last_d      = last_q;
    first_d     = first_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    mem_execute = 1'b0;
    done        = 1'b0;
    exec_start  = 1'b0;
    ptr_inc     = ptr_q + 1'b1;
    case (state_q)
      IDLE: if (start) begin
        base_d  = base_addr;
        ver_d   = verify_en;
        cnt_d   = '0;
        ptr_d   = '0;
        wsum_d  = '0;
        rsum_d  = '0;
        err_d   = 1'b0;
        state_d = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wdata_d = in_data;
          last_d  = in_last;
          addr_d  = base_q + ptr_q;
          func_d  = FUNC_WRITE;
          state_d = WR_ISSUE;
        end
      end
      WR_ISSUE: if (mem_ready) begin
        mem_execute = 1'b1;
        first_d     = 1'b1;
        state_d     = WR_WAIT;
      end
      WR_WAIT: begin
        first_d = 1'b0;
        if (!first_q && mem_ready) begin
          cnt_d  = &cnt_q ? cnt_q : cnt_q + 1'b1;
          ptr_d  = ptr_inc;
          wsum_d = wsum_q ^ wdata_q;
          if (!last_q) begin
            state_d = ACCEPT;
          end else if (ver_q) begin
            ptr_d   = '0;
            addr_d  = base_q;
            func_d  = FUNC_READ;
            state_d = RD_ISSUE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      RD_ISSUE: if (mem_ready) begin
        mem_execute = 1'b1;
        first_d     = 1'b1;
        state_d     = RD_WAIT;
      end
      RD_WAIT: begin
        first_d = 1'b0;
        if (!first_q && mem_ready) begin
          rsum_d = rsum_q ^ read_data;
          ptr_d  = ptr_inc;
          if (ptr_inc < cnt_q) begin
            addr_d  = base_q + ptr_inc;
            state_d = RD_ISSUE;
          end else begin
            state_d = (rsum_d == wsum_q) ? FINISH : FAIL;
          end
        end
      end
      FINISH: begin
        done       = 1'b1;
        exec_start = 1'b1;
        state_d    = IDLE;
      end
      FAIL: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized sessions against a behavioural memory; expected commands are queued
// by the stimulus side and popped by a monitor on every mem_execute.
module tb_mem_loader;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam logic [1:0] FR = 2'b00;
    localparam logic [1:0] FW = 2'b01;

    logic clk = 1'b0;
    logic rst, start, verify_en, in_valid, in_last, in_ready;
    logic mem_ready, mem_execute, busy, done, error, exec_start;
    logic [AW-1:0] base_addr, address, word_count;
    logic [DW-1:0] in_data, read_data, write_data;
    logic [1:0]    mem_func;

    always #5 clk = ~clk;

    mem_loader #(.ADDR_W(AW), .DATA_W(DW), .FUNC_READ(FR), .FUNC_WRITE(FW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .verify_en(verify_en),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_ready(mem_ready), .read_data(read_data), .mem_execute(mem_execute),
        .mem_func(mem_func), .address(address), .write_data(write_data), .busy(busy),
        .done(done), .error(error), .word_count(word_count), .exec_start(exec_start)
    );

    typedef struct {
        logic [1:0]    f;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    cmd_t          expq[$];
    logic [DW-1:0] words[$];
    logic [DW-1:0] mem[256];
    int  checks = 0, errors = 0;
    int  n_exec = 0, n_done = 0, n_xs = 0;
    bit  corrupt_m = 0, slow_m = 0;
    int  mcnt = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: accepts a command on the edge it is strobed, then goes not-ready for a latency.
    always @(posedge clk) begin
        int lat;
        if (rst) begin
            mem_ready <= 1'b1;
            mcnt      <= 0;
        end else if (start && slow_m && !busy) begin
            mem_ready <= 1'b0;
            mcnt      <= 5;
        end else if (mem_execute) begin
            if (mem_func == FW) mem[address] <= write_data;
            else read_data <= mem[address] ^ DW'(corrupt_m && address == AW'(2));
            lat = slow_m ? 5 : $urandom_range(0, 3);
            mem_ready <= (lat == 0);
            mcnt      <= lat;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mem_ready <= 1'b1;
        end
    end

    initial read_data = '0;

    // Monitor: pops the scoreboard on each strobe and watches handshake invariants.
    always @(negedge clk) begin
        static int cyc = 0, last_exec = -100;
        static bit prev_exec = 0, hold = 0;
        static logic [1:0] cf;
        static logic [AW-1:0] ca;
        static logic [DW-1:0] cd;
        cmd_t e;
        cyc++;
        if (rst) begin
            hold      = 0;
            prev_exec = 0;
        end else begin
            if (mem_execute) begin
                n_exec++;
                check("exec_back_to_back", DW'(prev_exec), 0);
                check("exec_without_ready", DW'(mem_ready), 1);
                if (slow_m) check("slow_cmd_gap", DW'(cyc - last_exec >= 6), 1);
                last_exec = cyc;
                if (expq.size() == 0) check("unexpected_cmd", 1, 0);
                else begin
                    e = expq.pop_front();
                    check("cmd_func", DW'(mem_func), DW'(e.f));
                    check("cmd_addr", DW'(address), DW'(e.a));
                    if (e.f == FW) check("cmd_wdata", write_data, e.d);
                end
                hold = 1;
                cf = mem_func;
                ca = address;
                cd = write_data;
            end else if (hold) begin
                check("cmd_hold_stable", DW'(mem_func == cf && address == ca && write_data == cd), 1);
                if (mem_ready) hold = 0;
            end
            prev_exec = mem_execute;
            if (done) n_done++;
            if (exec_start) n_xs++;
        end
    end

    task automatic send(input logic [DW-1:0] w, input bit last);
        bit ok = 0;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        for (int k = 0; k < 500; k++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("in_ready_timeout", DW'(ok), 1);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'b0;
    endtask

    task automatic begin_session(input logic [AW-1:0] b, input bit v);
        start     = 1'b1;
        base_addr = b;
        verify_en = v;
        @(negedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        verify_en = 1'($urandom);
    endtask

    // Reference: n writes at b+i (mod 2^AW), then n reads in the same order when verifying;
    // a corrupted readback of address 2 always breaks the XOR match.
    task automatic run_session(input logic [AW-1:0] b, input bit v, input string tag);
        int n = words.size();
        bit hit = 0, fail, ok = 0;
        int d0 = n_done, x0 = n_xs;
        for (int i = 0; i < n; i++) begin
            expq.push_back('{FW, AW'(b + i), words[i]});
            if (AW'(b + i) == AW'(2)) hit = 1;
        end
        if (v) for (int i = 0; i < n; i++) expq.push_back('{FR, AW'(b + i), '0});
        fail = v && corrupt_m && hit;
        begin_session(b, v);
        for (int i = 0; i < n; i++) send(words[i], i == n - 1);
        for (int k = 0; k < 3000; k++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check({tag, "_idle_timeout"}, DW'(ok), 1);
        check({tag, "_word_count"}, DW'(word_count), DW'(n));
        check({tag, "_error"}, DW'(error), DW'(fail));
        check({tag, "_done_pulses"}, DW'(n_done - d0), DW'(!fail));
        check({tag, "_exec_start_pulses"}, DW'(n_xs - x0), DW'(!fail));
        check({tag, "_cmds_left"}, DW'(expq.size()), 0);
    endtask

    task automatic fill(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    initial begin
        int e0, e1;
        bit ok;
        rst = 1'b1;
        start = 0; base_addr = '0; verify_en = 0;
        in_valid = 0; in_data = '0; in_last = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", DW'(busy), 0);
        check("rst_in_ready", DW'(in_ready), 0);
        check("rst_mem_execute", DW'(mem_execute), 0);
        check("rst_done", DW'(done), 0);
        check("rst_error", DW'(error), 0);
        check("rst_exec_start", DW'(exec_start), 0);
        check("rst_word_count", DW'(word_count), 0);
        check("rst_address", DW'(address), 0);
        check("rst_write_data", write_data, 0);
        check("rst_mem_func", DW'(mem_func), 0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        fill(3); run_session(8'd1, 0, "noverify");
        fill(3); run_session(8'd1, 1, "verify");
        corrupt_m = 1;
        fill(3); run_session(8'd1, 1, "corrupt");
        check("corrupt_busy", DW'(busy), 0);
        corrupt_m = 0;
        slow_m = 1;
        fill(3); run_session(AW'($urandom_range(16, 200)), 1, "slow");
        slow_m = 0;
        fill(2); run_session(8'hFF, 1, "wrap");

        // Reset in the wait phase of the second write.
        fill(2);
        e0 = n_exec;
        expq.push_back('{FW, 8'd40, words[0]});
        expq.push_back('{FW, 8'd41, words[1]});
        begin_session(8'd40, 1);
        send(words[0], 0);
        send(words[1], 0);
        ok = 0;
        for (int k = 0; k < 500; k++) begin
            if (n_exec >= e0 + 2) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("midrst_second_write_timeout", DW'(ok), 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", DW'(busy), 0);
        check("midrst_in_ready", DW'(in_ready), 0);
        check("midrst_mem_execute", DW'(mem_execute), 0);
        check("midrst_done", DW'(done), 0);
        check("midrst_error", DW'(error), 0);
        check("midrst_exec_start", DW'(exec_start), 0);
        check("midrst_word_count", DW'(word_count), 0);
        check("midrst_address", DW'(address), 0);
        check("midrst_write_data", write_data, 0);
        check("midrst_mem_func", DW'(mem_func), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        e1 = n_exec;
        repeat (20) @(negedge clk);
        #1;
        check("midrst_no_more_cmds", DW'(n_exec - e1), 0);
        check("midrst_cmds_left", DW'(expq.size()), 0);

        fill(1); run_session(AW'($urandom), 1, "after_rst_one_word");
        for (int s = 0; s < 4; s++) begin
            fill($urandom_range(1, 6));
            run_session(AW'($urandom), 1'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
